nolan_led_blink_core: RTL and testbench
=======================================

Name: nolan_led_blink_core

Overview:
- Parametrised multi-channel LED blinker slot core on the standard MMIO slot bus (cs/read/write/addr[4:0]/wr_data/rd_data).
- Each channel has a programmable half-period in prescaled ticks and a 2-bit mode: off, on, blink or one-shot.
- A group phase-restart register keeps channels in step; all registers can be read back.
- Sits in an MMIO slot between the bus decoder and the board LED pins.

Parameters:
- N_LED, 4, number of LED channels; legal range 1..16.
- PERIOD_W, 32, width of each half-period register.
- PRESCALE, 100000, clk cycles per tick (1 ms at 100 MHz); legal minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  slot select.
- read  in  1  read strobe; rd_data does not depend on it.
- write  in  1  write strobe; a write occurs on the rising edge where cs&write=1.
- addr  in  5  register address.
- wr_data  in  32  write data.
- rd_data  out  32  read data; combinational from addr and current register state.
- led_out  out  N_LED  LED drive, registered, 1 = lit.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - all half-period registers = 0; mode register = 0 (all off).
  - prescaler = 0; per-channel tick counters = 0; phase bits = 0; led_out = 0.
- Register map (addresses not listed: writes are ignored, reads return 0):
  - 0..N_LED-1, RW, half-period of channel addr (wr_data[PERIOD_W-1:0]). Write clears that channel's counter and sets its phase to 1.
  - 0x10, RW, mode. Channel i uses bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 one-shot. Bits at and above 2*N_LED read as 0.
  - 0x11, WO, restart mask. For every channel with wr_data[i]=1: counter cleared and phase set to 1, all in the same cycle. Reads return 0.
  - 0x12, RO, live status. Bits [N_LED-1:0] = led_out, upper bits 0.
- Prescaler: counts 0..PRESCALE-1. tick=1 for one clk cycle when the count equals PRESCALE-1, then the count wraps to 0. Free-running; not affected by register writes.
- Per-channel counter, active only in blink or one-shot mode with half-period P>0. On tick:
  - if counter==P-1: counter to 0 and the reached_end event fires;
  - otherwise counter increments.
- Blink mode: reached_end toggles phase.
- One-shot mode: reached_end clears phase and rewrites this channel's mode field to 00 in the same cycle.
- Entering one-shot mode (write to 0x10 that changes a field to 11) clears the counter and sets phase to 1.
- led_out[i], registered one cycle after the state it reflects:
  - off: 0.
  - on: 1.
  - blink or one-shot: phase, but 0 if P=0; the counter is held at 0 while P=0.
- A lit blink channel is therefore on for P ticks and off for P ticks. In cycles, each half lasts P*PRESCALE cycles, ±PRESCALE on the first half after a write or restart because the prescaler is free-running.
- Write timing: the register updates on the write edge; rd_data reflects the new value from the next cycle. led_out reflects the new state one edge after the register updates.
- Simultaneous events:
  - a write to a channel's period or restart in the same cycle as that channel's reached_end: the write wins (counter 0, phase 1).
  - a write to 0x10 in the same cycle as a one-shot completion: the written mode value wins.
- Shrinking P below the current counter value: the channel restarts as on a period write, so there is no wrap through 2^PERIOD_W.
- Reset asserted mid-operation returns everything to reset values on that edge. Bus writes during reset are ignored.

Test Plan:
- Reset, then read addrs 0..3, 0x10 and 0x12 -> all return 0; led_out=0.
- PRESCALE=4: write addr0=5, then 0x10=0x2 -> led_out[0] is high for 20 clk and low for 20 clk, repeating (±4 clk on the first high period); rd addr0=5.
- 0x10=0x0000_00E4 (ch0 off, ch1 on, ch2 blink, ch3 one-shot), P2=P3=3 -> led_out[1]=1 constant; ch2 toggles every 12 clk; ch3 stays high about 12 clk, then 0 forever, and a read of 0x10 returns 0x24.
- Ch1 P=2, ch2 P=6, both blink; write 0x11=0x6 -> both go high on the next edge. ch1 toggles at 8/16/24 clk and ch2 at 24 clk, so they are aligned at the 24-clk edge.
- Blink mode with P=0 -> led_out=0 indefinitely. Writing P=1 -> toggles every tick (4 clk).
- Mid-blink reset pulse -> led_out, mode and periods all 0 on the next edge. Write to 0x15 -> no state change; reading 0x15 returns 0.

Source files
------------

// File: rtl/nolan_led_blink_core.sv
// nolan_led_blink_core
//   Multi-channel LED blinker on the MMIO slot bus. Each channel has a
//   half-period (in prescaled ticks) and a 2-bit mode: off, on, blink, one-shot.
//   A restart mask realigns any set of channels in one cycle.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   cs       slot select
//   read     read strobe (rd_data is combinational and ignores it)
//   write    write strobe; a write happens on the edge where cs & write
//   addr     register address
//   wr_data  write data
//   rd_data  read data, combinational from addr and register state
//   led_out  registered LED drive, 1 = lit
//
// Register map
//   0..N_LED-1  RW  half-period of channel addr
//   0x10        RW  mode, 2 bits per channel (00 off, 01 on, 10 blink, 11 one-shot)
//   0x11        WO  restart mask
//   0x12        RO  live LED status
module nolan_led_blink_core #(
    parameter int N_LED    = 4,
    parameter int PERIOD_W = 32,
    parameter int PRESCALE = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    output logic [N_LED-1:0] led_out
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [4:0] ADDR_MODE    = 5'h10;
    localparam logic [4:0] ADDR_RESTART = 5'h11;
    localparam logic [4:0] ADDR_STATUS  = 5'h12;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic                tick;
    logic [PERIOD_W-1:0] period_q [N_LED];
    logic [PERIOD_W-1:0] period_d [N_LED];
    logic [PERIOD_W-1:0] cnt_q    [N_LED];
    logic [PERIOD_W-1:0] cnt_d    [N_LED];
    logic [2*N_LED-1:0]  mode_q, mode_d;
    logic [N_LED-1:0]    phase_q, phase_d;
    logic [N_LED-1:0]    led_q, led_d;

    logic                wr_en, mode_wr, restart_wr;
    logic [N_LED-1:0]    restart, counting, at_end;
    mode_e               cur_mode [N_LED];

    // The read strobe has no side effects and only the low wr_data bits are
    // decoded; fold them here so they are visibly accounted for.
    logic unused_bus;
    assign unused_bus = ^{read, wr_data};

    assign wr_en      = cs & write;
    assign mode_wr    = wr_en && (addr == ADDR_MODE);
    assign restart_wr = wr_en && (addr == ADDR_RESTART);

    // Free-running prescaler; register writes never disturb it.
    always_comb begin
        tick    = (presc_q == PS_LAST);
        presc_d = tick ? '0 : presc_q + PS_W'(1);
    end

    // NOTE: every output of this block is assigned a default before any
    // condition, so no path leaves a variable unassigned and no latch appears.
    always_comb begin
        mode_d = mode_q;
        if (mode_wr) begin
            mode_d = wr_data[2*N_LED-1:0];
        end

        for (int i = 0; i < N_LED; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            phase_d[i]  = phase_q[i];
            cur_mode[i] = mode_e'(mode_q[2*i +: 2]);

            if (wr_en && (addr == 5'(i))) begin
                period_d[i] = wr_data[PERIOD_W-1:0];
            end

            // A period write also covers shrinking P below the live count:
            // the counter restarts instead of wrapping through 2^PERIOD_W.
            restart[i] = (wr_en && (addr == 5'(i)))
                      || (restart_wr && wr_data[i])
                      || (mode_wr && (cur_mode[i] != MODE_ONESHOT)
                                  && (mode_e'(wr_data[2*i +: 2]) == MODE_ONESHOT));

            counting[i] = ((cur_mode[i] == MODE_BLINK) || (cur_mode[i] == MODE_ONESHOT))
                       && (period_q[i] != '0);
            at_end[i]   = (cnt_q[i] == period_q[i] - PERIOD_W'(1));

            // Restart has priority over a coincident end-of-half event.
            if (restart[i]) begin
                cnt_d[i]   = '0;
                phase_d[i] = 1'b1;
            end else if (period_q[i] == '0) begin
                cnt_d[i] = '0;
            end else if (counting[i] && tick) begin
                if (at_end[i]) begin
                    cnt_d[i] = '0;
                    if (cur_mode[i] == MODE_BLINK) begin
                        phase_d[i] = ~phase_q[i];
                    end else begin
                        phase_d[i] = 1'b0;
                        // A bus write to the mode register in this cycle wins.
                        if (!mode_wr) begin
                            mode_d[2*i +: 2] = MODE_OFF;
                        end
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                end
            end

            unique case (cur_mode[i])
                MODE_OFF: led_d[i] = 1'b0;
                MODE_ON:  led_d[i] = 1'b1;
                default:  led_d[i] = phase_q[i] && (period_q[i] != '0);
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_LED; i++) begin
            if (addr == 5'(i)) begin
                rd_data = 32'(period_q[i]);
            end
        end
        if (addr == ADDR_MODE) begin
            rd_data = 32'(mode_q);
        end else if (addr == ADDR_STATUS) begin
            rd_data = 32'(led_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            mode_q  <= '0;
            phase_q <= '0;
            led_q   <= '0;
            // NOTE: the period and counter arrays are small flop banks, not RAM,
            // so they are reset explicitly along with the rest of the state.
            for (int i = 0; i < N_LED; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            presc_q <= presc_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            for (int i = 0; i < N_LED; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_nolan_led_blink_core.sv
// Testbench for nolan_led_blink_core with N_LED=4, PERIOD_W=32, PRESCALE=4.
module tb_nolan_led_blink_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  led_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb_q [$];

    typedef struct {
        logic        do_wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [18];

    nolan_led_blink_core #(
        .N_LED   (4),
        .PERIOD_W(32),
        .PRESCALE(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cs    = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        cs    = 1'b0;
        write = 1'b0;
    endtask

    // Expected value goes into the scoreboard when the read is driven and is
    // popped once the combinational read data has settled.
    task automatic bus_rd(input logic [4:0] a, input logic [31:0] e, input string name);
        logic [31:0] exp_v;
        @(negedge clk);
        cs   = 1'b1;
        read = 1'b1;
        addr = a;
        sb_q.push_back(e);
        #1;
        exp_v = sb_q.pop_front();
        check(name, rd_data, exp_v);
        cs   = 1'b0;
        read = 1'b0;
    endtask

    task automatic wait_level(input int idx, input logic val, input int budget, input string name);
        int n = 0;
        while (led_out[idx] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(led_out[idx]), 32'(val));
    endtask

    // Number of cycles the LED keeps its current level; returns on the first
    // negedge showing the new level.
    task automatic run_len(input int idx, output int n);
        logic v;
        v = led_out[idx];
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (led_out[idx] === v && n < 300);
    endtask

    initial begin
        int   len;
        int   c1;
        logic acc;
        logic p1, p2, ch1_now;

        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;

        vecs[0]  = '{1'b0, 5'h00, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'h01, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 5'h02, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'h03, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'h10, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 5'h11, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 5'h12, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 5'h15, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 5'h00, 32'h5,        32'h5};
        vecs[9]  = '{1'b1, 5'h01, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 5'h03, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[11] = '{1'b1, 5'h10, 32'hFFFFFF55, 32'h55};
        vecs[12] = '{1'b1, 5'h11, 32'hF,        32'h0};
        vecs[13] = '{1'b0, 5'h12, 32'h0,        32'hF};
        vecs[14] = '{1'b1, 5'h04, 32'h7,        32'h0};
        vecs[15] = '{1'b1, 5'h13, 32'h1234,     32'h0};
        vecs[16] = '{1'b0, 5'h01, 32'h0,        32'hDEADBEEF};
        vecs[17] = '{1'b0, 5'h00, 32'h0,        32'h5};

        // Reset state and register map
        do_reset();
        check("reset_led", 32'(led_out), 32'h0);
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].do_wr) begin
                bus_wr(vecs[i].addr, vecs[i].wdata);
            end
            bus_rd(vecs[i].addr, vecs[i].exp_rd, $sformatf("regmap[%0d] addr 0x%0h", i, vecs[i].addr));
        end

        // Blink P=5: 20-cycle halves
        do_reset();
        bus_wr(5'h00, 32'd5);
        bus_wr(5'h10, 32'h2);
        wait_level(0, 1'b1, 10, "blink5_rise");
        run_len(0, len);
        check_range("blink5_first_high", len, 16, 24);
        run_len(0, len);
        check_range("blink5_low", len, 20, 20);
        run_len(0, len);
        check_range("blink5_high", len, 20, 20);
        run_len(0, len);
        check_range("blink5_low2", len, 20, 20);
        bus_rd(5'h00, 32'd5, "blink5_period_rd");

        // Mixed modes: off / on / blink / one-shot
        do_reset();
        bus_wr(5'h02, 32'd3);
        bus_wr(5'h03, 32'd3);
        bus_wr(5'h10, 32'hE4);
        wait_level(3, 1'b1, 10, "oneshot_rise");
        run_len(3, len);
        check_range("oneshot_high", len, 9, 12);
        run_len(2, len);
        check_range("mixed_ch2_low", len, 12, 12);
        run_len(2, len);
        check_range("mixed_ch2_high", len, 12, 12);
        check("mixed_static_bits", 32'(led_out & 4'b1011), 32'h2);
        acc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            acc = acc | led_out[3];
        end
        check("oneshot_stays_off", 32'(acc), 32'h0);
        bus_rd(5'h10, 32'h24, "oneshot_mode_cleared");

        // Restart mask aligns ch1 (P=2) and ch2 (P=6)
        do_reset();
        bus_wr(5'h01, 32'd2);
        bus_wr(5'h02, 32'd6);
        bus_wr(5'h10, 32'h28);
        repeat (37) @(negedge clk);
        bus_wr(5'h11, 32'h6);
        @(negedge clk);
        check("restart_both_high", 32'(led_out[2:1]), 32'h3);
        p1 = led_out[1];
        p2 = led_out[2];
        c1 = 0;
        ch1_now = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ch1_now = (led_out[1] !== p1);
            if (ch1_now) c1++;
            p1 = led_out[1];
            if (led_out[2] !== p2) break;
        end
        check("restart_ch1_toggles", 32'(c1), 32'd3);
        check("restart_same_edge", 32'(ch1_now), 32'h1);

        // Blink with P=0 stays dark; P=1 toggles every tick
        do_reset();
        bus_wr(5'h10, 32'h2);
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = acc | led_out[0];
        end
        check("p0_dark", 32'(acc), 32'h0);
        bus_wr(5'h00, 32'd1);
        wait_level(0, 1'b1, 8, "p1_rise");
        run_len(0, len);
        check_range("p1_first_high", len, 1, 4);
        run_len(0, len);
        check_range("p1_low", len, 4, 4);
        run_len(0, len);
        check_range("p1_high", len, 4, 4);

        // Reset mid-blink, with a bus write held during reset
        wait_level(0, 1'b1, 8, "pre_reset_lit");
        @(negedge clk);
        reset   = 1'b1;
        cs      = 1'b1;
        write   = 1'b1;
        addr    = 5'h00;
        wr_data = 32'd9;
        @(negedge clk);
        reset = 1'b0;
        cs    = 1'b0;
        write = 1'b0;
        check("midreset_led", 32'(led_out), 32'h0);
        bus_rd(5'h00, 32'h0, "midreset_period");
        bus_rd(5'h10, 32'h0, "midreset_mode");
        bus_wr(5'h15, 32'hFFFFFFFF);
        bus_rd(5'h15, 32'h0, "unmapped_rd");
        bus_rd(5'h10, 32'h0, "unmapped_mode_intact");
        bus_rd(5'h03, 32'h0, "unmapped_period_intact");
        check("unmapped_led", 32'(led_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
